egg_timer_ctrl: RTL and testbench

Sequencing controller for the egg-timer countdown datapath (the 4-digit BCD mm:ss down-counter with `wrtEn`/`decEn` controls). It turns user button pulses into datapath load/decrement strobes, derives the 1 Hz decrement tick from the system clock, detects expiry from the datapath's current value, and drives the alarm output. It sits between the debounced button logic and the countdown register bank.

---
 rtl/egg_timer_ctrl.sv | 171 +++++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: sequencing controller for the 4-digit BCD mm:ss egg-timer countdown datapath.
// Build option: define ALARM_BLINK_EN to make the alarm blink at the tick rate instead of a steady level.
module egg_timer_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int ALARM_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] timeIn,
  output logic        wrtEn,
  output logic        decEn,
  output logic        running,
  output logic        alarm,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_ALARM = 3'd3
  } state_e;

  localparam int CW = $clog2(TICK_DIV);
  // A one-cycle alarm still needs a 1-bit counter to keep the vector legal.
  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_INC  = CW'(1);
  localparam logic [AW-1:0] ACNT_MAX  = AW'(ALARM_CYCLES - 1);
  localparam logic [AW-1:0] ACNT_ZERO = AW'(0);
  localparam logic [AW-1:0] ACNT_INC  = AW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          running_q;
  logic          alarm_q, alarm_d;
  logic          time_zero_s;
  logic          tick_s;

  assign time_zero_s = (timeIn == 16'h0000);
  assign tick_s      = (cnt_q == CNT_MAX);

  // Next-state, counter updates and the two combinational datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acnt_d  = acnt_q;
    wrtEn   = 1'b0;
    decEn   = 1'b0;
    if (reset) begin
      state_d = S_IDLE;
      cnt_d   = CNT_ZERO;
      acnt_d  = ACNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (load) begin
            wrtEn = 1'b1;
          end else if (start && !time_zero_s) begin
            state_d = S_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          // Never decrement a zero value: the datapath must not underflow.
          decEn = tick_s && !time_zero_s;
          if (time_zero_s) begin
            state_d = S_ALARM;
            acnt_d  = ACNT_ZERO;
          end else if (stop) begin
            state_d = S_PAUSE;
          end else if (tick_s) begin
            cnt_d = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_INC;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (load) begin
            wrtEn   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (start && !time_zero_s) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_ALARM: begin
          if (stop) begin
            state_d = S_IDLE;
            acnt_d  = ACNT_ZERO;
          end else if (load) begin
            wrtEn   = 1'b1;
            state_d = S_IDLE;
            acnt_d  = ACNT_ZERO;
          end else if (acnt_q == ACNT_MAX) begin
            state_d = S_IDLE;
            acnt_d  = ACNT_ZERO;
          end else begin
            acnt_d = acnt_q + ACNT_INC;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          acnt_d  = ACNT_ZERO;
        end
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  localparam logic [CW-1:0] BLINK_HALF = CW'(TICK_DIV / 2);
  logic [CW-1:0] blink_q, blink_d;

  // Phase within the current tick period; tracks alarm counter mod TICK_DIV.
  always_comb begin
    blink_d = CNT_ZERO;
    if ((state_d == S_ALARM) && (state_q == S_ALARM)) begin
      blink_d = (blink_q == CNT_MAX) ? CNT_ZERO : (blink_q + CNT_INC);
    end else begin
      blink_d = CNT_ZERO;
    end
  end

  assign alarm_d = (state_d == S_ALARM) && (blink_d < BLINK_HALF);
`else
  assign alarm_d = (state_d == S_ALARM);
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      acnt_q    <= ACNT_ZERO;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef ALARM_BLINK_EN
      blink_q   <= CNT_ZERO;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == S_RUN);
      alarm_q   <= alarm_d;
`ifdef ALARM_BLINK_EN
      blink_q   <= blink_d;
`endif
    end
  end

  assign state   = state_q;
  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with a BCD datapath model and an expected-value queue.
module tb_egg_timer_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int ALARM_CYCLES = 10;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        load   = 1'b0;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic [15:0] timeIn;
  logic        wrtEn, decEn, running, alarm;
  logic [2:0]  state;

  logic [15:0] dp_q;
  logic [15:0] preset = 16'h0000;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } exp_t;
  exp_t sb[$];

  egg_timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_CYCLES(ALARM_CYCLES)) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop),
    .timeIn(timeIn), .wrtEn(wrtEn), .decEn(decEn), .running(running),
    .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Countdown register bank model driven by the controller strobes.
  always @(posedge clk) begin
    if (reset)      dp_q <= 16'h0000;
    else if (wrtEn) dp_q <= preset;
    else if (decEn) dp_q <= bcd_dec(dp_q);
  end
  assign timeIn = dp_q;

  function automatic logic exp_alarm(input int i);
`ifdef ALARM_BLINK_EN
    return (i % TICK_DIV) < (TICK_DIV / 2);
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, compare mid-cycle.
  task automatic step(input string tag, input logic rst, input logic ld, input logic st,
                      input logic sp, input logic [2:0] es, input logic ew, input logic ed,
                      input logic ea);
    exp_t e;
    exp_t got;
    logic [6:0] obs;
    @(posedge clk);
    #1;
    reset = rst; load = ld; start = st; stop = sp;
    e.tag = tag;
    e.exp = {es, (es == 3'd1), ea, ew, ed};
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    obs = {state, running, alarm, wrtEn, decEn};
    checks++;
    assert (obs === got.exp) else begin
      failures++;
      $error("FAIL %s observed{state,run,alarm,wrt,dec}=%b expected=%b", got.tag, obs, got.exp);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    // reset, idle behaviour
    step("rst_load",       1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("idle",           1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("start_zero",     1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("start_zero_ign", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("idle_stop",      1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

    // full countdown from 0x0003, load ignored in RUN, alarm then timeout
    preset = 16'h0003;
    step("load_idle",      1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("load_once",      1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("start3",         1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 13; k++)
      step($sformatf("run3_k%0d", k), 1'b0, (k == 1), 1'b0, 1'b0, 3'd1, 1'b0,
           ((k % TICK_DIV == 0) && (k <= 12)), 1'b0);
    for (int i = 0; i < ALARM_CYCLES; i++)
      step($sformatf("alarm3_i%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, exp_alarm(i));
    step("alarm_timeout",  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // pause at cnt=2, resume preserves partial tick
    preset = 16'h0010;
    step("load10",         1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("start10",        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("run10_c0",       1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("run10_c1",       1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("stop_c2",        1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 7; p++)
      step($sformatf("pause_%0d", p), 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    step("resume",         1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    step("resume_c2",      1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("resume_dec",     1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    step("stop_and_start", 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step("pause_stop",     1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step("pause_to_idle",  1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // stop in the 3rd alarm cycle
    preset = 16'h0001;
    step("load1",          1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("start1",         1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++)
      step($sformatf("run1_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, (k == 4), 1'b0);
    step("al_stop_i0",     1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, exp_alarm(0));
    step("al_stop_i1",     1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, exp_alarm(1));
    step("al_stop_i2",     1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, exp_alarm(2));
    step("al_stop_idle",   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // load during alarm ends it with a write strobe
    step("load1b",         1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("start1b",        1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++)
      step($sformatf("run1b_k%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, (k == 4), 1'b0);
    preset = 16'h0002;
    step("al_load",        1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, exp_alarm(0));
    step("al_load_idle",   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // reset in RUN on a tick cycle suppresses decEn
    step("start2",         1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("run2_k1",        1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("run2_k2",        1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("run2_k3",        1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("rst_in_run",     1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    step("after_rst",      1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("start_after_rst",1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step("still_idle",     1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
